multichannel_accumulator: RTL and testbench
===========================================

# multichannel_accumulator

Parametrised, multi-channel version of the team's 16-bit feedback adder. It holds CHANNELS independent running sums, each WIDTH bits wide. Every accepted sample is added into the sum selected by its channel index, and an overflow flag is tracked per channel. A dump sequence streams out every sum in channel order and clears each one as it is read. The block sits between sample sources and the readout and statistics logic.

## Interface
- WIDTH, 16, width of input samples and of each accumulator (minimum 2).
- CHANNELS, 4, number of accumulators (2 to 64).
- CH_W, $clog2(CHANNELS), width of the channel index.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present on in_data/in_channel.
- in_channel  in  CH_W  target accumulator.
- in_data  in  WIDTH  unsigned sample.
- in_ready  out  1  block accepts samples; transfer occurs when in_valid && in_ready.
- dump_start  in  1  one-cycle request to read out and clear all channels.
- out_valid  out  1  out_* qualifies a result.
- out_channel  out  CH_W  channel of out_data.
- out_data  out  WIDTH  accumulator value.
- out_last  out  1  final beat of a dump.
- out_dump  out  1  beat belongs to a dump (0 = accumulate echo).
- overflow  out  CHANNELS  sticky per-channel overflow flags.

## Operation
- FSM states:
  - IDLE: in_ready=1. Samples are accepted. dump_start is sampled here.
  - DUMP: in_ready=0. An index i steps from 0 to CHANNELS-1, one channel per cycle.
- FSM transitions:
  - IDLE to DUMP: on a clock edge with dump_start=1 while in IDLE.
  - DUMP to IDLE: on the edge that emits channel CHANNELS-1.
  - dump_start is ignored while in DUMP.
- Accumulate:
  - On an accepted sample, sum = acc[in_channel] + in_data, computed WIDTH+1 bits wide.
  - acc[in_channel] is updated on that edge.
  - If the carry is set, overflow[in_channel] is set to 1.
- Channel range: a sample with in_channel >= CHANNELS is dropped. No state changes and no output is produced.
- Echo: every accepted, in-range sample produces one output beat with out_valid=1, out_dump=0, out_last=0, out_channel=in_channel and out_data = the new acc value.
- Back-to-back samples on the same channel accumulate correctly at one sample per cycle; there is no stall.
- Dump beat i:
  - out_valid=1, out_dump=1, out_channel=i, out_data=acc[i].
  - out_last=1 only when i=CHANNELS-1.
  - On the same edge, acc[i] is cleared to 0 and overflow[i] is cleared to 0.
- Simultaneous in_valid and dump_start in IDLE: the sample is applied first. The dump then reports the updated value, and the sample's echo beat comes out before dump beat 0.
- Overflow is never cleared except by a dump of that channel or by reset.

## Timing
- Reset state: all acc=0, overflow=0, state IDLE, out_valid/out_last/out_dump=0, out_channel=0, out_data=0.
- in_ready=0 in the cycle reset is high. in_ready=1 from the first cycle after reset is released.
- Reset asserted during a dump aborts it. All state returns to reset values on that edge, and no further dump beats are produced.
- Accumulate latency: an input accepted at edge k gives out_valid=1 in the cycle after edge k. All outputs are registered.
- Dump latency: dump_start sampled at edge k gives dump beat 0 in the cycle after edge k+1, then one beat per cycle.
- Dump duration: CHANNELS beats. in_ready is 0 for exactly CHANNELS cycles.
- The output is not back-pressured; the consumer must accept one beat per cycle.

## Configuration
- Macro: MULTICHANNEL_ACCUMULATOR_SATURATE_EN.
- Defined: on carry, acc is set to 2^WIDTH-1 and held there, and overflow is set. Further additions leave acc saturated.
- Undefined: acc wraps modulo 2^WIDTH; overflow is still set on carry.

## Test plan
- Reset check: after reset, feed ch0 with 5, 7, 9 on consecutive cycles → echo out_data values 5, 12, 21 on ch0; overflow=0.
- Interleave (WIDTH=16, CHANNELS=4): send ch1 +100, ch3 +1, ch1 +50, then dump → dump beats give ch0=0, ch1=150, ch2=0, ch3=1. out_last is 1 on beat 3 only. All acc read 0 after the dump.
- Overflow: preload ch2 to 0xFFF0, then add 0x0020.
  - Without the macro: echo 0x0010, overflow[2]=1.
  - With MULTICHANNEL_ACCUMULATOR_SATURATE_EN: echo 0xFFFF, overflow[2]=1.
  - In both builds, a following dump clears overflow[2].
- Collision: in_valid on ch0 (+3) with dump_start in the same cycle → echo of 3, then dump beat 0 reports 3. in_ready stays 0 for 4 cycles, and in_valid during that time is not accepted.
- Invalid index: with CHANNELS=3, send in_channel=3 → no out_valid; all acc unchanged.
- Reset mid-dump: assert reset at dump beat 1 → out_valid=0 from the next cycle and all acc are 0.

Source files
------------

// File: rtl/multichannel_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : multichannel_accumulator
// Purpose  : CHANNELS independent WIDTH-bit running sums with per-channel
//            sticky overflow, echo of every accepted sample, and a
//            read-and-clear dump of all channels in index order.
// Options  : MULTICHANNEL_ACCUMULATOR_SATURATE_EN - saturate instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module multichannel_accumulator #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_channel,
  input  logic [WIDTH-1:0]    in_data,
  output logic                in_ready,
  input  logic                dump_start,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_channel,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic                out_dump,
  output logic [CHANNELS-1:0] overflow
);

  localparam logic [CH_W-1:0] C_LAST_IDX = CH_W'(CHANNELS - 1);
  localparam logic [CH_W:0]   C_NUM_CH   = (CH_W + 1)'(CHANNELS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CH_W-1:0]     r_idx;
  logic [WIDTH-1:0]    r_acc [CHANNELS];
  logic [CHANNELS-1:0] r_ovf;

  logic                r_out_valid;
  logic [CH_W-1:0]     r_out_channel;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_last;
  logic                r_out_dump;

  logic                w_in_range;
  logic                w_accept;
  logic                w_dump_last;
  logic [WIDTH:0]      w_sum;
  logic                w_carry;
  logic [WIDTH-1:0]    w_new_acc;

  // Ready is forced low while reset is asserted so no sample can sneak in.
  assign in_ready    = (r_state == IDLE) && !reset;
  assign w_in_range  = ({1'b0, in_channel} < C_NUM_CH);
  assign w_accept    = in_valid && in_ready && w_in_range;
  assign w_dump_last = (r_state == DUMP) && (r_idx == C_LAST_IDX);

  assign w_sum   = {1'b0, r_acc[in_channel]} + {1'b0, in_data};
  assign w_carry = w_sum[WIDTH];

`ifdef MULTICHANNEL_ACCUMULATOR_SATURATE_EN
  assign w_new_acc = w_carry ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  assign w_new_acc = w_sum[WIDTH-1:0];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (dump_start) w_next_state = DUMP;
      DUMP:    if (w_dump_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A sample accepted together with dump_start lands before dump beat 0 reads it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx         <= '0;
      r_ovf         <= '0;
      r_out_valid   <= 1'b0;
      r_out_channel <= '0;
      r_out_data    <= '0;
      r_out_last    <= 1'b0;
      r_out_dump    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_dump  <= 1'b0;
      if (r_state == DUMP) begin
        r_out_valid   <= 1'b1;
        r_out_dump    <= 1'b1;
        r_out_last    <= w_dump_last;
        r_out_channel <= r_idx;
        r_out_data    <= r_acc[r_idx];
        r_acc[r_idx]  <= '0;
        r_ovf[r_idx]  <= 1'b0;
        r_idx         <= w_dump_last ? '0 : r_idx + CH_W'(1);
      end else if (w_accept) begin
        r_acc[in_channel] <= w_new_acc;
        if (w_carry) begin
          r_ovf[in_channel] <= 1'b1;
        end
        r_out_valid   <= 1'b1;
        r_out_channel <= in_channel;
        r_out_data    <= w_new_acc;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_channel = r_out_channel;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign out_dump    = r_out_dump;
  assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_multichannel_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_multichannel_accumulator
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multichannel_accumulator;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int C3 = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_channel;
  logic [15:0] in_data;
  logic        dump_start;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_channel;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_dump;
  logic [3:0]  overflow;

  logic        v3;
  logic [1:0]  c3;
  logic [15:0] d3;
  logic        s3;
  logic        r3_ready;
  logic        o3_valid;
  logic [1:0]  o3_ch;
  logic [15:0] o3_data;
  logic        o3_last;
  logic        o3_dump;
  logic [2:0]  o3_ovf;

  multichannel_accumulator #(.WIDTH(W), .CHANNELS(C)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_channel(in_channel), .in_data(in_data),
    .in_ready(in_ready), .dump_start(dump_start),
    .out_valid(out_valid), .out_channel(out_channel), .out_data(out_data),
    .out_last(out_last), .out_dump(out_dump), .overflow(overflow)
  );

  multichannel_accumulator #(.WIDTH(W), .CHANNELS(C3)) dut3 (
    .clock(clock), .reset(reset),
    .in_valid(v3), .in_channel(c3), .in_data(d3),
    .in_ready(r3_ready), .dump_start(s3),
    .out_valid(o3_valid), .out_channel(o3_ch), .out_data(o3_data),
    .out_last(o3_last), .out_dump(o3_dump), .overflow(o3_ovf)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: sums as plain integers, a pending-dump countdown.
  int       m_acc [C];
  logic [3:0] m_ovf;
  int       m_busy;
  bit       m_init = 0;
  logic     e_valid, e_last, e_dump;
  int       e_ch, e_data;
  int       m_s, m_i;

  always @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < C; c++) m_acc[c] = 0;
      m_ovf = '0; m_busy = 0; m_init = 1;
      e_valid = 0; e_last = 0; e_dump = 0; e_ch = 0; e_data = 0;
    end else if (m_busy != 0) begin
      m_i = C - m_busy;
      e_valid = 1; e_dump = 1; e_last = (m_i == C - 1);
      e_ch = m_i; e_data = m_acc[m_i];
      m_acc[m_i] = 0; m_ovf[m_i] = 1'b0;
      m_busy = m_busy - 1;
    end else begin
      e_valid = 0; e_last = 0; e_dump = 0;
      if (in_valid === 1'b1 && int'(in_channel) < C) begin
        m_s = m_acc[in_channel] + int'(in_data);
        if (m_s > 65535) begin
          m_ovf[in_channel] = 1'b1;
`ifdef MULTICHANNEL_ACCUMULATOR_SATURATE_EN
          m_s = 65535;
`else
          m_s = m_s - 65536;
`endif
        end
        m_acc[in_channel] = m_s;
        e_valid = 1; e_ch = int'(in_channel); e_data = m_s;
      end
      if (dump_start === 1'b1) m_busy = C;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      chk("model_ready", in_ready, (!reset && m_busy == 0));
      chk("model_valid", out_valid, e_valid);
      chk("model_ovf", overflow, m_ovf);
      if (e_valid) begin
        chk("model_ch", out_channel, e_ch);
        chk("model_data", out_data, e_data);
        chk("model_last", out_last, e_last);
        chk("model_dump", out_dump, e_dump);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int ch, input int d);
    in_valid = 1'b1; in_channel = 2'(ch); in_data = 16'(d);
    cyc();
  endtask

  logic [15:0] d_data [C];
  logic        d_last [C];
  logic [1:0]  d_ch   [C];

  task automatic do_dump();
    in_valid = 1'b0; dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    for (int i = 0; i < C; i++) begin
      cyc();
      @(negedge clock);
      d_data[i] = out_data; d_last[i] = out_last; d_ch[i] = out_channel;
    end
    cyc();
  endtask

  int exp_il [C] = '{0, 150, 0, 1};
  int exp_c3 [C3] = '{0, 7, 0};

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_channel = '0; in_data = '0; dump_start = 1'b0;
    v3 = 1'b0; c3 = '0; d3 = '0; s3 = 1'b0;
    repeat (3) cyc();
    @(negedge clock);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_channel", out_channel, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_dump", out_dump, 0);
    chk("rst_ovf", overflow, 0);
    cyc();

    // Running sum on channel 0
    reset = 1'b0; in_valid = 1'b1; in_channel = 2'd0; in_data = 16'd5;
    @(negedge clock); chk("ready_post_rst", in_ready, 1);
    cyc();
    in_data = 16'd7;
    @(negedge clock); chk("echo_5", out_data, 5); chk("echo_5_dump", out_dump, 0);
    cyc();
    in_data = 16'd9;
    @(negedge clock); chk("echo_12", out_data, 12);
    cyc();
    in_valid = 1'b0;
    @(negedge clock); chk("echo_21", out_data, 21); chk("echo_ovf", overflow, 0);
    cyc();

    // Interleaved channels then dump
    do_dump();
    send(1, 100); send(3, 1); send(1, 50);
    do_dump();
    for (int i = 0; i < C; i++) begin
      chk($sformatf("il_data%0d", i), d_data[i], exp_il[i]);
      chk($sformatf("il_ch%0d", i), d_ch[i], i);
      chk($sformatf("il_last%0d", i), d_last[i], (i == C - 1));
    end
    do_dump();
    for (int i = 0; i < C; i++) chk($sformatf("il_cleared%0d", i), d_data[i], 0);

    // Overflow on channel 2
    send(2, 16'hFFF0);
    send(2, 16'h0020);
    in_valid = 1'b0;
    @(negedge clock);
`ifdef MULTICHANNEL_ACCUMULATOR_SATURATE_EN
    chk("ovf_echo", out_data, 16'hFFFF);
`else
    chk("ovf_echo", out_data, 16'h0010);
`endif
    chk("ovf_flag", overflow[2], 1);
    cyc();
    do_dump();
    @(negedge clock); chk("ovf_cleared", overflow[2], 0);
    cyc();

    // Sample and dump_start collide
    in_valid = 1'b1; in_channel = 2'd0; in_data = 16'd3; dump_start = 1'b1;
    cyc();
    in_channel = 2'd1; in_data = 16'd9; dump_start = 1'b0;
    @(negedge clock);
    chk("col_echo_valid", out_valid, 1); chk("col_echo_dump", out_dump, 0);
    chk("col_echo_data", out_data, 3); chk("col_ready0", in_ready, 0);
    for (int i = 0; i < C; i++) begin
      cyc();
      if (i == C - 1) in_valid = 1'b0;
      @(negedge clock);
      chk($sformatf("col_beat_dump%0d", i), out_dump, 1);
      chk($sformatf("col_beat_data%0d", i), out_data, (i == 0) ? 3 : 0);
      chk($sformatf("col_ready_b%0d", i), in_ready, (i == C - 1));
    end
    cyc();

    // Out-of-range channel on the three-channel instance
    v3 = 1'b1; c3 = 2'd1; d3 = 16'd7;
    cyc();
    c3 = 2'd3; d3 = 16'd9;
    @(negedge clock); chk("c3_echo_valid", o3_valid, 1); chk("c3_echo_data", o3_data, 7);
    cyc();
    v3 = 1'b0;
    @(negedge clock); chk("c3_invalid_no_valid", o3_valid, 0);
    cyc();
    s3 = 1'b1;
    cyc();
    s3 = 1'b0;
    for (int i = 0; i < C3; i++) begin
      cyc();
      @(negedge clock);
      chk($sformatf("c3_dump_data%0d", i), o3_data, exp_c3[i]);
      chk($sformatf("c3_dump_last%0d", i), o3_last, (i == C3 - 1));
      chk($sformatf("c3_dump_flag%0d", i), o3_dump, 1);
    end
    cyc();
    @(negedge clock); chk("c3_ready", r3_ready, 1); chk("c3_ovf", o3_ovf, 0);
    cyc();

    // Reset during a dump
    send(0, 11); send(2, 22);
    in_valid = 1'b0; dump_start = 1'b1;
    cyc();
    dump_start = 1'b0;
    cyc();
    @(negedge clock); chk("rmd_beat0", out_data, 11);
    cyc();
    reset = 1'b1;
    @(negedge clock); chk("rmd_beat1_valid", out_valid, 1); chk("rmd_beat1_ch", out_channel, 1);
    cyc();
    reset = 1'b0;
    @(negedge clock); chk("rmd_abort", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clock); chk($sformatf("rmd_quiet%0d", i), out_valid, 0);
    end
    cyc();
    do_dump();
    for (int i = 0; i < C; i++) chk($sformatf("rmd_zero%0d", i), d_data[i], 0);

    // Randomized traffic against the model
    for (int t = 0; t < 3000; t++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_channel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       in_data = 16'($urandom_range(0, 15));
        1:       in_data = 16'($urandom_range(16'hF000, 16'hFFFF));
        default: in_data = 16'($urandom);
      endcase
      dump_start = ($urandom_range(0, 29) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0; in_valid = 1'b0; dump_start = 1'b0;
    repeat (10) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
